systolic_mac_ctrl: RTL
======================

// Module: systolic_mac_ctrl
// PURPOSE
//  Sequencer for a DIM x DIM systolic array of tpumac cells. On a start request it
//  loads the C accumulators row by row, then runs the skewed A/B stream. After that
//  it reads the C rows back out. It drives the array-wide en/WrEn strobes and the
//  row and cycle indices used by the A/B skew buffers and the C read/write muxes.
//  It sits between the MMIO command register and the array.
// PARAMETERS
//  DIM    8                   array dimension (rows = cols = DIM), DIM >= 2
//  CNT_W  $clog2(3*DIM-1)     width of the cycle counter
// PORTS
//  clk        in   1      clock
//  rst        in   1      reset
//  start      in   1      start a job; sampled only in IDLE
//  accum      in   1      sampled with start: 1 = skip LOAD_C, accumulate onto current C
//  feed_rdy   in   1      A/B skew buffers have data for this cycle; 0 stalls COMPUTE
//  abort      in   1      abandon current job; return to IDLE next cycle
//  en         out  1      array MAC enable
//  WrEn       out  1      array C write enable (row selected by c_row)
//  c_row      out  $clog2(DIM)  C row index for LOAD_C writes and READ_C reads
//  feed_cnt   out  CNT_W  COMPUTE cycle index, 0..3*DIM-3, to the skew buffers
//  rd_valid   out  1      c_row output data is valid this cycle (READ_C)
//  busy       out  1      high in every state except IDLE
//  done       out  1      one-cycle pulse at job completion
// BEHAVIOUR
//  - Reset: clk and one asynchronous, active-high reset rst. Asserting rst forces state IDLE
//    and all outputs and counters to 0 immediately, regardless of clk.
//  - States: IDLE -> LOAD_C -> COMPUTE -> READ_C -> DONE -> IDLE. All transitions are
//    registered; outputs are decoded from state and counters, with no combinational path
//    from inputs except as noted.
//  - IDLE: all outputs 0. When start=1 at a posedge, go to LOAD_C, or to COMPUTE if
//    accum=1. accum is latched at that edge.
//  - LOAD_C: lasts DIM cycles. WrEn=1, en=0, c_row counts 0..DIM-1. After row DIM-1,
//    go to COMPUTE.
//  - COMPUTE: lasts 3*DIM-2 cycles in which feed_rdy is high.
//    - en = feed_rdy (combinational), WrEn=0.
//    - feed_cnt advances only on cycles with feed_rdy=1. It holds while feed_rdy=0, so a
//      stall freezes the array with no data loss.
//    - After the cycle with feed_cnt=3*DIM-3 and feed_rdy=1, go to READ_C.
//  - READ_C: lasts DIM cycles. rd_valid=1, en=0, WrEn=0, c_row counts 0..DIM-1.
//    Then go to DONE.
//  - DONE: lasts 1 cycle. done=1, busy=1, then go to IDLE.
//  - busy is 1 in LOAD_C, COMPUTE, READ_C and DONE.
//  - A new job can be accepted on the cycle after DONE.
//  - start outside IDLE is ignored. It is not queued.
//  - abort in any non-IDLE state:
//    - next state is IDLE, and done is NOT pulsed;
//    - the abort cycle's own outputs are unchanged;
//    - abort has priority over every other transition, including the last-cycle exits.
//  - abort together with start in IDLE: abort wins and the controller stays in IDLE.
//  - Counters: c_row wraps to 0 on the state exit. feed_cnt is cleared when COMPUTE is
//    entered and never exceeds 3*DIM-3.
// TESTING  (DIM=4)
//  1. Reset mid-COMPUTE (feed_cnt=5), rst=1 between clock edges -> all outputs 0 at once,
//     IDLE after release, next start runs normally.
//  2. start=1, accum=0, feed_rdy=1 held -> WrEn=1 for 4 cycles (c_row 0,1,2,3), then en=1 for
//     10 cycles (feed_cnt 0..9), then rd_valid for 4 cycles, then done for 1 cycle; busy=19 cycles.
//  3. start=1, accum=1 -> no WrEn cycles; en starts the cycle after start; busy=15 cycles.
//  4. feed_rdy=0 for 3 cycles at feed_cnt=6 -> en=0 and feed_cnt holds at 6 during the stall;
//     COMPUTE lasts 13 cycles; done arrives 3 cycles later than in test 2.
//  5. abort at feed_cnt=2 -> IDLE the next cycle, no done pulse; start pulsed again in
//     COMPUTE -> ignored, busy never drops early.
//  6. Bench MAC array, A=B=identity, C preload = row index -> READ_C rows equal
//     preload + identity, and match the software model.

Source files
------------

// File: rtl/systolic_mac_ctrl_if.sv
// rtl/systolic_mac_ctrl_if.sv - command/strobe bundle between the host side and the systolic array sequencer
interface systolic_mac_ctrl_if #(
    parameter int DIM   = 8,
    parameter int CNT_W = $clog2(3*DIM-1)
);
    logic                    start;
    logic                    accum;
    logic                    feed_rdy;
    logic                    abort;
    logic                    en;
    logic                    WrEn;
    logic [$clog2(DIM)-1:0]  c_row;
    logic [CNT_W-1:0]        feed_cnt;
    logic                    rd_valid;
    logic                    busy;
    logic                    done;

    modport master (
        output start, accum, feed_rdy, abort,
        input  en, WrEn, c_row, feed_cnt, rd_valid, busy, done
    );

    modport slave (
        input  start, accum, feed_rdy, abort,
        output en, WrEn, c_row, feed_cnt, rd_valid, busy, done
    );
endinterface

// File: rtl/systolic_mac_ctrl.sv
// rtl/systolic_mac_ctrl.sv - LOAD_C / COMPUTE / READ_C sequencer for a DIM x DIM tpumac array
module systolic_mac_ctrl #(
    parameter int DIM   = 8,
    parameter int CNT_W = $clog2(3*DIM-1)
) (
    input  logic                clk,
    input  logic                rst,
    systolic_mac_ctrl_if.slave  bus
);
    localparam int              RW        = $clog2(DIM);
    localparam logic [RW-1:0]   ROW_LAST  = RW'(DIM-1);
    localparam logic [CNT_W-1:0] FEED_LAST = CNT_W'(3*DIM-3);

    typedef enum logic [2:0] {
        IDLE,
        LOAD_C,
        COMPUTE,
        READ_C,
        DONE
    } state_t;

    state_t            state;
    logic [RW-1:0]     row;
    logic [CNT_W-1:0]  cnt;
    logic              wr_q;
    logic              cmp_q;
    logic              rv_q;
    logic              busy_q;
    logic              done_q;

    // en is the only output with a combinational input path: a feed stall freezes the array immediately
    assign bus.en       = cmp_q & bus.feed_rdy;
    assign bus.WrEn     = wr_q;
    assign bus.c_row    = row;
    assign bus.feed_cnt = cnt;
    assign bus.rd_valid = rv_q;
    assign bus.busy     = busy_q;
    assign bus.done     = done_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            row    <= '0;
            cnt    <= '0;
            wr_q   <= 1'b0;
            cmp_q  <= 1'b0;
            rv_q   <= 1'b0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
        end else if (state != IDLE && bus.abort) begin
            // abort beats every exit, including the last-cycle ones, and never pulses done
            state  <= IDLE;
            row    <= '0;
            cnt    <= '0;
            wr_q   <= 1'b0;
            cmp_q  <= 1'b0;
            rv_q   <= 1'b0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.start && !bus.abort) begin
                        busy_q <= 1'b1;
                        row    <= '0;
                        cnt    <= '0;
                        if (bus.accum) begin
                            state <= COMPUTE;
                            cmp_q <= 1'b1;
                        end else begin
                            state <= LOAD_C;
                            wr_q  <= 1'b1;
                        end
                    end
                end
                LOAD_C: begin
                    if (row == ROW_LAST) begin
                        state <= COMPUTE;
                        row   <= '0;
                        cnt   <= '0;
                        wr_q  <= 1'b0;
                        cmp_q <= 1'b1;
                    end else begin
                        row <= row + 1'b1;
                    end
                end
                COMPUTE: begin
                    if (bus.feed_rdy) begin
                        if (cnt == FEED_LAST) begin
                            state <= READ_C;
                            cnt   <= '0;
                            cmp_q <= 1'b0;
                            rv_q  <= 1'b1;
                            row   <= '0;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                end
                READ_C: begin
                    if (row == ROW_LAST) begin
                        state  <= DONE;
                        row    <= '0;
                        rv_q   <= 1'b0;
                        done_q <= 1'b1;
                    end else begin
                        row <= row + 1'b1;
                    end
                end
                DONE: begin
                    state  <= IDLE;
                    done_q <= 1'b0;
                    busy_q <= 1'b0;
                end
                default: begin
                    state  <= IDLE;
                    row    <= '0;
                    cnt    <= '0;
                    wr_q   <= 1'b0;
                    cmp_q  <= 1'b0;
                    rv_q   <= 1'b0;
                    busy_q <= 1'b0;
                    done_q <= 1'b0;
                end
            endcase
        end
    end
endmodule
